// File: rtl/ex_stage_pkg.sv
// Shared Y86 execute-stage constants: instruction codes, ALU functions,
// condition codes and the NOP bundle loaded on reset or bubble.
package ex_stage_pkg;

  localparam int unsigned WORD = 32;
  localparam int unsigned BYTE = 8;

  typedef logic [WORD-1:0] word_t;
  typedef logic [BYTE-1:0] byte_t;

  typedef enum logic [BYTE-1:0] {
    IHALT   = 8'h0,
    INOP    = 8'h1,
    IRRMOVL = 8'h2,
    IIRMOVL = 8'h3,
    IRMMOVL = 8'h4,
    IMRMOVL = 8'h5,
    IOPL    = 8'h6,
    IJXX    = 8'h7,
    ICALL   = 8'h8,
    IRET    = 8'h9,
    IPUSHL  = 8'hA,
    IPOPL   = 8'hB
  } icode_e;

  typedef enum logic [BYTE-1:0] {
    ALUADD = 8'h0,
    ALUSUB = 8'h1,
    ALUAND = 8'h2,
    ALUXOR = 8'h3
  } alu_e;

  typedef enum logic [BYTE-1:0] {
    C_YES = 8'h0,
    C_LE  = 8'h1,
    C_L   = 8'h2,
    C_E   = 8'h3,
    C_NE  = 8'h4,
    C_GE  = 8'h5,
    C_G   = 8'h6
  } cond_e;

  localparam byte_t RNONE = 8'hF;
  localparam byte_t RESP  = 8'h4;

  localparam byte_t NOP_ICODE = INOP;
  localparam logic  NOP_CND   = 1'b0;
  localparam word_t NOP_VALE  = '0;
  localparam word_t NOP_VALA  = '0;
  localparam byte_t NOP_DSTE  = RNONE;
  localparam byte_t NOP_DSTM  = RNONE;

  function automatic logic cond_eval(input byte_t ifun, input logic zf,
                                     input logic sf, input logic of);
    logic r;
    r = 1'b0;
    case (ifun)
      C_YES:   r = 1'b1;
      C_LE:    r = (sf ^ of) | zf;
      C_L:     r = sf ^ of;
      C_E:     r = zf;
      C_NE:    r = ~zf;
      C_GE:    r = ~(sf ^ of);
      C_G:     r = ~(sf ^ of) & ~zf;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input bundle, pipeline control, forwarding and EX/MEM outputs of ex_stage.
interface ex_stage_if;
  import ex_stage_pkg::*;

  byte_t ex_icode;
  byte_t ex_ifun;
  word_t ex_valA;
  word_t ex_valB;
  word_t ex_valC;
  byte_t ex_dstE;
  byte_t ex_dstM;
  logic  cc_inhibit;
  logic  ex_stall;
  logic  ex_bubble;

  word_t e_valE;
  byte_t e_dstE;
  logic  e_cnd;

  byte_t mem_icode;
  logic  mem_cnd;
  word_t mem_valE;
  word_t mem_valA;
  byte_t mem_dstE;
  byte_t mem_dstM;

  modport master (
    output ex_icode, ex_ifun, ex_valA, ex_valB, ex_valC, ex_dstE, ex_dstM,
    output cc_inhibit, ex_stall, ex_bubble,
    input  e_valE, e_dstE, e_cnd,
    input  mem_icode, mem_cnd, mem_valE, mem_valA, mem_dstE, mem_dstM
  );

  modport slave (
    input  ex_icode, ex_ifun, ex_valA, ex_valB, ex_valC, ex_dstE, ex_dstM,
    input  cc_inhibit, ex_stall, ex_bubble,
    output e_valE, e_dstE, e_cnd,
    output mem_icode, mem_cnd, mem_valE, mem_valA, mem_dstE, mem_dstM
  );
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational Y86 ALU: result plus zero/sign/overflow flags. SUB is b - a.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  word_t alu_a,
  input  word_t alu_b,
  input  byte_t alufun,
  output word_t val_e,
  output logic  zf,
  output logic  sf,
  output logic  of
);

  always_comb begin
    val_e = alu_b + alu_a;
    of    = (alu_a[WORD-1] == alu_b[WORD-1]) && (val_e[WORD-1] != alu_a[WORD-1]);
    case (alufun)
      ALUSUB: begin
        val_e = alu_b - alu_a;
        of    = (alu_b[WORD-1] != alu_a[WORD-1]) && (val_e[WORD-1] != alu_b[WORD-1]);
      end
      ALUAND: begin
        val_e = alu_a & alu_b;
        of    = 1'b0;
      end
      ALUXOR: begin
        val_e = alu_a ^ alu_b;
        of    = 1'b0;
      end
      default: ;
    endcase
    zf = (val_e == '0);
    sf = val_e[WORD-1];
  end

endmodule

// File: rtl/ex_stage.sv
// Y86 execute stage: operand select, ALU, condition codes, cmov/jXX condition
// evaluation and the EX/MEM pipeline register with stall/bubble control.
module ex_stage
  import ex_stage_pkg::*;
(
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  word_t alu_a;
  word_t alu_b;
  byte_t alu_fun;
  word_t alu_val;
  logic  alu_zf, alu_sf, alu_of;
  logic  zf_q, sf_q, of_q;
  logic  cnd;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (bus.ex_icode)
      IRRMOVL, IOPL:             alu_a = bus.ex_valA;
      IIRMOVL, IRMMOVL, IMRMOVL: alu_a = bus.ex_valC;
      ICALL, IPUSHL:             alu_a = 32'hFFFF_FFFC;
      IRET, IPOPL:               alu_a = 32'd4;
      default:                   alu_a = '0;
    endcase
    case (bus.ex_icode)
      IRMMOVL, IMRMOVL, IOPL, ICALL, IRET, IPUSHL, IPOPL: alu_b = bus.ex_valB;
      default:                                            alu_b = '0;
    endcase
    alu_fun = (bus.ex_icode == IOPL) ? bus.ex_ifun : byte_t'(ALUADD);
  end

  ex_stage_alu u_alu (
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alufun (alu_fun),
    .val_e  (alu_val),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // Condition evaluation reads only the registered flags, so an OPl never
  // observes its own update.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (bus.ex_icode == IOPL && !bus.cc_inhibit && !bus.ex_stall) begin
      zf_q <= alu_zf;
      sf_q <= alu_sf;
      of_q <= alu_of;
    end
  end

  always_comb begin
    cnd        = cond_eval(bus.ex_ifun, zf_q, sf_q, of_q);
    bus.e_cnd  = cnd;
    bus.e_valE = alu_val;
    bus.e_dstE = (bus.ex_icode == IRRMOVL && !cnd) ? RNONE : bus.ex_dstE;
  end

  always_ff @(posedge clk) begin
    if (rst || (!bus.ex_stall && bus.ex_bubble)) begin
      bus.mem_icode <= NOP_ICODE;
      bus.mem_cnd   <= NOP_CND;
      bus.mem_valE  <= NOP_VALE;
      bus.mem_valA  <= NOP_VALA;
      bus.mem_dstE  <= NOP_DSTE;
      bus.mem_dstM  <= NOP_DSTM;
    end else if (!bus.ex_stall) begin
      bus.mem_icode <= bus.ex_icode;
      bus.mem_cnd   <= cnd;
      bus.mem_valE  <= alu_val;
      bus.mem_valA  <= bus.ex_valA;
      bus.mem_dstE  <= bus.e_dstE;
      bus.mem_dstM  <= bus.ex_dstM;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with hand-computed expectations.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  ex_stage_if bus ();

  ex_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] icode, input logic [7:0] ifun,
                       input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc,
                       input logic [7:0] de, input logic [7:0] dm);
    bus.ex_icode = icode;
    bus.ex_ifun  = ifun;
    bus.ex_valA  = va;
    bus.ex_valB  = vb;
    bus.ex_valC  = vc;
    bus.ex_dstE  = de;
    bus.ex_dstM  = dm;
    #1;
  endtask

  // Probe the registered flags through a jXX with the given condition.
  task automatic jcnd(input logic [7:0] ifun, input logic expv, input string tag);
    bus.ex_icode = 8'h7;
    bus.ex_ifun  = ifun;
    #1;
    check(tag, {31'd0, bus.e_cnd}, {31'd0, expv});
  endtask

  logic [7:0]  st_icode [8] = '{8'hA, 8'hB, 8'h5, 8'h8, 8'h9, 8'h3, 8'h4, 8'h1};
  logic [31:0] st_va    [8] = '{32'hAA, 32'hBB, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 32'h5};
  logic [31:0] st_vb    [8] = '{32'h100, 32'hFC, 32'h20, 32'h100, 32'hFC, 32'h99, 32'h10, 32'h6};
  logic [31:0] st_vc    [8] = '{32'h0, 32'h0, 32'h8, 32'h0, 32'h0, 32'h1234, 32'h4, 32'h7};
  logic [31:0] st_ve    [8] = '{32'hFC, 32'h100, 32'h28, 32'hFC, 32'h100, 32'h1234, 32'h14, 32'h0};

  initial begin
    rst            = 1'b1;
    bus.cc_inhibit = 1'b0;
    bus.ex_stall   = 1'b0;
    bus.ex_bubble  = 1'b0;
    drive(8'h1, 8'h0, 32'h0, 32'h0, 32'h0, 8'hF, 8'hF);
    tick;
    tick;
    rst = 1'b0;

    check("rst_icode", {24'd0, bus.mem_icode}, 32'h1);
    check("rst_dstE", {24'd0, bus.mem_dstE}, 32'hF);
    check("rst_dstM", {24'd0, bus.mem_dstM}, 32'hF);
    check("rst_valE", bus.mem_valE, 32'h0);
    check("rst_valA", bus.mem_valA, 32'h0);
    check("rst_cnd", {31'd0, bus.mem_cnd}, 32'h0);
    jcnd(8'h3, 1'b1, "rst_cc_e");
    jcnd(8'h2, 1'b0, "rst_cc_l");
    jcnd(8'h1, 1'b1, "rst_cc_le");
    jcnd(8'h0, 1'b1, "rst_cc_yes");
    jcnd(8'h7, 1'b0, "rst_cc_bad_ifun");

    // ADD overflow
    drive(8'h6, 8'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 8'h3, 8'hF);
    check("add_ovf_e_valE", bus.e_valE, 32'h8000_0000);
    check("add_ovf_e_dstE", {24'd0, bus.e_dstE}, 32'h3);
    jcnd(8'h3, 1'b1, "add_own_cc_not_seen");
    bus.ex_icode = 8'h6;
    bus.ex_ifun  = 8'h0;
    tick;
    check("add_ovf_mem_valE", bus.mem_valE, 32'h8000_0000);
    check("add_ovf_mem_icode", {24'd0, bus.mem_icode}, 32'h6);
    check("add_ovf_mem_dstE", {24'd0, bus.mem_dstE}, 32'h3);
    check("add_ovf_mem_cnd", {31'd0, bus.mem_cnd}, 32'h1);
    jcnd(8'h2, 1'b0, "add_ovf_l");
    jcnd(8'h3, 1'b0, "add_ovf_e");
    jcnd(8'h4, 1'b1, "add_ovf_ne");
    jcnd(8'h6, 1'b1, "add_ovf_g");

    // SUB equal, first inhibited
    bus.cc_inhibit = 1'b1;
    drive(8'h6, 8'h1, 32'h5, 32'h5, 32'h0, 8'h3, 8'hF);
    check("sub_eq_e_valE", bus.e_valE, 32'h0);
    tick;
    bus.cc_inhibit = 1'b0;
    jcnd(8'h3, 1'b0, "inhibit_zf");
    jcnd(8'h2, 1'b0, "inhibit_l");
    drive(8'h6, 8'h1, 32'h5, 32'h5, 32'h0, 8'h3, 8'hF);
    tick;
    jcnd(8'h3, 1'b1, "sub_eq_zf");
    jcnd(8'h2, 1'b0, "sub_eq_l");

    drive(8'h6, 8'h1, 32'h5, 32'h3, 32'h0, 8'h3, 8'hF);
    check("sub_neg_e_valE", bus.e_valE, 32'hFFFF_FFFE);
    tick;
    jcnd(8'h2, 1'b1, "sub_neg_l");
    jcnd(8'h3, 1'b0, "sub_neg_e");
    jcnd(8'h1, 1'b1, "sub_neg_le");

    drive(8'h6, 8'h1, 32'h1, 32'h8000_0000, 32'h0, 8'h3, 8'hF);
    check("sub_ovf_e_valE", bus.e_valE, 32'h7FFF_FFFF);
    tick;
    jcnd(8'h2, 1'b1, "sub_ovf_l");
    jcnd(8'h5, 1'b0, "sub_ovf_ge");

    // Untaken / taken cmove
    drive(8'h2, 8'h3, 32'h55, 32'h0, 32'h0, 8'h2, 8'hF);
    check("cmov_nt_e_cnd", {31'd0, bus.e_cnd}, 32'h0);
    check("cmov_nt_e_dstE", {24'd0, bus.e_dstE}, 32'hF);
    check("cmov_nt_e_valE", bus.e_valE, 32'h55);
    tick;
    check("cmov_nt_mem_dstE", {24'd0, bus.mem_dstE}, 32'hF);
    check("cmov_nt_mem_cnd", {31'd0, bus.mem_cnd}, 32'h0);
    check("cmov_nt_mem_icode", {24'd0, bus.mem_icode}, 32'h2);
    drive(8'h6, 8'h1, 32'h9, 32'h9, 32'h0, 8'h3, 8'hF);
    tick;
    drive(8'h2, 8'h3, 32'h66, 32'h0, 32'h0, 8'h2, 8'hF);
    check("cmov_t_e_dstE", {24'd0, bus.e_dstE}, 32'h2);
    tick;
    check("cmov_t_mem_dstE", {24'd0, bus.mem_dstE}, 32'h2);
    check("cmov_t_mem_cnd", {31'd0, bus.mem_cnd}, 32'h1);
    check("cmov_t_mem_valE", bus.mem_valE, 32'h66);

    // AND / XOR
    drive(8'h6, 8'h2, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 8'h3, 8'hF);
    check("and_e_valE", bus.e_valE, 32'h8000_0000);
    tick;
    jcnd(8'h2, 1'b1, "and_l");
    jcnd(8'h3, 1'b0, "and_e");
    drive(8'h6, 8'h3, 32'h1234_5678, 32'h1234_5678, 32'h0, 8'h3, 8'hF);
    check("xor_e_valE", bus.e_valE, 32'h0);
    tick;
    jcnd(8'h3, 1'b1, "xor_zf");
    jcnd(8'h2, 1'b0, "xor_l");

    // Stack / memory address arithmetic
    for (int i = 0; i < 8; i++) begin
      drive(st_icode[i], 8'h0, st_va[i], st_vb[i], st_vc[i], 8'h4, 8'h7);
      tick;
      check($sformatf("addr_valE_%0d", i), bus.mem_valE, st_ve[i]);
      check($sformatf("addr_valA_%0d", i), bus.mem_valA, st_va[i]);
      check($sformatf("addr_dstM_%0d", i), {24'd0, bus.mem_dstM}, 32'h7);
    end

    // Stall for 3 cycles while inputs change
    drive(8'h3, 8'h0, 32'h0, 32'h0, 32'h77, 8'h6, 8'hF);
    tick;
    check("pre_stall_valE", bus.mem_valE, 32'h77);
    bus.ex_stall = 1'b1;
    drive(8'h6, 8'h0, 32'h1, 32'h1, 32'h0, 8'h2, 8'h3);
    tick;
    tick;
    drive(8'h6, 8'h1, 32'h2, 32'h9, 32'h0, 8'h2, 8'h3);
    tick;
    check("stall_valE", bus.mem_valE, 32'h77);
    check("stall_icode", {24'd0, bus.mem_icode}, 32'h3);
    check("stall_dstE", {24'd0, bus.mem_dstE}, 32'h6);
    check("stall_dstM", {24'd0, bus.mem_dstM}, 32'hF);
    bus.ex_stall = 1'b0;
    jcnd(8'h3, 1'b1, "stall_cc_zf");
    jcnd(8'h2, 1'b0, "stall_cc_l");

    // Stall and bubble together
    drive(8'h3, 8'h0, 32'h0, 32'h0, 32'h99, 8'h5, 8'hF);
    tick;
    bus.ex_stall  = 1'b1;
    bus.ex_bubble = 1'b1;
    drive(8'h6, 8'h0, 32'h1, 32'h1, 32'h0, 8'h2, 8'h3);
    tick;
    check("sb_valE", bus.mem_valE, 32'h99);
    check("sb_icode", {24'd0, bus.mem_icode}, 32'h3);
    check("sb_dstE", {24'd0, bus.mem_dstE}, 32'h5);
    bus.ex_stall  = 1'b0;
    bus.ex_bubble = 1'b0;
    jcnd(8'h3, 1'b1, "sb_cc_zf");

    // Bubble alone
    drive(8'h3, 8'h0, 32'h33, 32'h0, 32'h42, 8'h5, 8'h8);
    bus.ex_bubble = 1'b1;
    tick;
    bus.ex_bubble = 1'b0;
    check("bub_icode", {24'd0, bus.mem_icode}, 32'h1);
    check("bub_valE", bus.mem_valE, 32'h0);
    check("bub_valA", bus.mem_valA, 32'h0);
    check("bub_dstE", {24'd0, bus.mem_dstE}, 32'hF);
    check("bub_dstM", {24'd0, bus.mem_dstM}, 32'hF);
    check("bub_cnd", {31'd0, bus.mem_cnd}, 32'h0);

    // Reset during a stall
    drive(8'h6, 8'h0, 32'h1, 32'h1, 32'h0, 8'h2, 8'h3);
    tick;
    drive(8'h3, 8'h0, 32'h33, 32'h0, 32'h55, 8'h5, 8'h8);
    tick;
    check("pre_rst_valE", bus.mem_valE, 32'h55);
    jcnd(8'h3, 1'b0, "pre_rst_zf");
    drive(8'h3, 8'h0, 32'h33, 32'h0, 32'h55, 8'h5, 8'h8);
    bus.ex_stall = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.ex_stall = 1'b0;
    check("rst_stall_icode", {24'd0, bus.mem_icode}, 32'h1);
    check("rst_stall_valE", bus.mem_valE, 32'h0);
    check("rst_stall_valA", bus.mem_valA, 32'h0);
    check("rst_stall_dstE", {24'd0, bus.mem_dstE}, 32'hF);
    jcnd(8'h3, 1'b1, "rst_stall_cc_zf");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Y86 execute stage, consuming the ex_* bundle registered by the ID/EX pipeline register.
- Contains the ALU, the condition-code register (ZF/SF/OF) and cmovXX/jXX condition evaluation.
- Registers its results into the EX/MEM pipeline register, with stall and bubble control from pipeline control logic.
- Also drives same-cycle forwarding values back to decode.

Parameters:
- None. Widths come from shared defines: `WORD = 32 bits, `BYTE = byte field holding icode/ifun/register IDs.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_icode  in  `BYTE  instruction code.
- ex_ifun  in  `BYTE  function code (ALU op or condition).
- ex_valA  in  `WORD  operand A.
- ex_valB  in  `WORD  operand B.
- ex_valC  in  `WORD  constant.
- ex_dstE  in  `BYTE  E destination register.
- ex_dstM  in  `BYTE  M destination register.
- cc_inhibit  in  1  suppress CC update (exception in MEM/WB).
- ex_stall  in  1  hold the EX/MEM register.
- ex_bubble  in  1  load a NOP into the EX/MEM register.
- e_valE  out  `WORD  combinational ALU result, for forwarding.
- e_dstE  out  `BYTE  combinational effective dstE, for forwarding.
- e_cnd  out  1  combinational condition result.
- mem_icode, mem_cnd, mem_valE, mem_valA, mem_dstE, mem_dstM  out  `BYTE/1/`WORD/`WORD/`BYTE/`BYTE  registered EX/MEM outputs.

Behaviour:
- Clock and reset: one clock domain (clk); rst synchronous, active-high.
- Reset values:
  - mem_icode = INOP (1); mem_cnd = 0; mem_valE = mem_valA = 0; mem_dstE = mem_dstM = RNONE (0xF).
  - CC: ZF = 1, SF = 0, OF = 0.
- aluA select:
  - rrmovl(2) / OPl(6) -> valA.
  - irmovl(3) / rmmovl(4) / mrmovl(5) -> valC.
  - call(8) / pushl(A) -> -4 (0xFFFFFFFC).
  - ret(9) / popl(B) -> +4.
  - Otherwise 0.
- aluB select:
  - rmmovl / mrmovl / OPl / call / ret / pushl / popl -> valB.
  - rrmovl / irmovl -> 0.
  - Otherwise 0.
- ALU function: ex_ifun when icode = OPl, else ADD.
  - Codes: ADD 0, SUB 1, AND 2, XOR 3.
  - SUB computes aluB - aluA. Arithmetic is 32-bit modulo, wrap-around with no trap.
- Flag computation (t = result):
  - ZF = (t == 0); SF = t[31].
  - OF on ADD: sign(A) == sign(B) and sign(t) != sign(A).
  - OF on SUB: sign(B) != sign(A) and sign(t) != sign(B).
  - OF = 0 on AND and XOR.
- CC register:
  - Loads {ZF, SF, OF} at the clock edge only when icode = OPl and !cc_inhibit and !ex_stall and !rst.
  - Otherwise holds its value.
  - Instructions see CC as updated by the preceding OPl; an instruction never sees its own update.
- e_cnd (from the registered CC, by ifun):
  - 0 -> 1 (always)
  - 1 le -> (SF^OF)|ZF
  - 2 l -> SF^OF
  - 3 e -> ZF
  - 4 ne -> !ZF
  - 5 ge -> !(SF^OF)
  - 6 g -> !(SF^OF)&!ZF
  - Other ifun -> 0.
- e_dstE: RNONE when icode = rrmovl and !e_cnd (untaken cmov), else ex_dstE.
- EX/MEM register update, priority order:
  - rst -> reset values.
  - Else ex_stall -> hold all mem_* values.
  - Else ex_bubble -> NOP pattern, identical to the reset values.
  - Else load {ex_icode, e_cnd, e_valE, ex_valA, e_dstE, ex_dstM}.
- Latency: 1 cycle from the ex_* inputs to the mem_* outputs. The e_* outputs are combinational within the same cycle.
- Stall with a bubble in the same cycle: stall wins, and the CC update is suppressed.
- Reset mid-stall: reset wins.

Decomposition:
- Shared defines (defines.v):
  - Icode constants IHALT..IPOPL.
  - ALU codes ALUADD/ALUSUB/ALUAND/ALUXOR.
  - Condition codes C_YES..C_G.
  - RNONE (0xF) and RESP (4).
  - NOP bundle values.
- Sub-module alu:
  - Inputs aluA, aluB, alufun.
  - Outputs valE, zf, sf, of.
  - Purely combinational and instantiated once.
- CC register, condition logic and EX/MEM register stay in ex_stage.

Test Plan:
1. Reset then idle: hold rst for 2 cycles -> mem_icode = 1, mem_dstE = mem_dstM = 0xF, mem_valE = 0; e_cnd for ifun = 3 is 1 (ZF = 1).
2. OPl ADD overflow: valA = 0x7FFFFFFF, valB = 1 -> e_valE = 0x80000000; next cycle CC = {ZF 0, SF 1, OF 1}; a following jXX with ifun = 2 (l) gives e_cnd = 0.
3. OPl SUB equal: valA = valB = 5 -> valE = 0 and ZF = 1. Same case with cc_inhibit = 1 -> CC unchanged from its previous value.
4. Untaken cmov: CC ZF = 0; rrmovl ifun = 3, dstE = 2 -> e_dstE = 0xF and mem_dstE = 0xF. With ZF = 1 -> mem_dstE = 2.
5. Stack ops:
   - pushl, valB = 0x100 -> mem_valE = 0xFC.
   - popl, valB = 0xFC -> mem_valE = 0x100.
   - mrmovl, valC = 8, valB = 0x20 -> mem_valE = 0x28.
6. Control: ex_stall high for 3 cycles while inputs change -> mem_* frozen and CC frozen. ex_stall and ex_bubble high together -> hold. ex_bubble alone -> NOP pattern. rst asserted during a stall -> reset values next edge.
